// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready in (A,B,C,ALU_c) and out (result,z,cf,v); iterative MUL/MAC/DIV/REM
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [3:0]       ALU_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             cf,
  output logic             v
);
  localparam int W = WIDTH;
  localparam int SW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2;
  localparam logic [3:0] OP_PASS = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                         OP_OR = 4'd4, OP_XOR = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                         OP_SRA = 4'd8, OP_MUL = 4'd9, OP_MAC = 4'd10, OP_DIV = 4'd11,
                         OP_REM = 4'd12, OP_SLT = 4'd13;
  logic [1:0] state;
  logic [SW-1:0] cnt;
  logic [2*W-1:0] acc, mc, acc_s, mc_s, acc_n;
  logic [W-1:0] mp, mp_s, rem, rem_s, rem_n, quo, quo_s, quo_n, dvs, dvs_s;
  logic [W:0] sh, diff, sum, dif;
  logic [W-1:0] res1, fin;
  logic [SW-1:0] sa;
  logic idle, fire, mul_op, div_op, is_rem, cf1, v1, big, fin_v;
  assign idle = state == IDLE;
  assign in_ready = !reset && idle && (!out_valid || out_ready);
  assign fire = in_valid && in_ready;
  always_comb begin
    mul_op = ALU_c == OP_MUL || ALU_c == OP_MAC;
    div_op = (ALU_c == OP_DIV || ALU_c == OP_REM) && B != '0;
    acc_s = idle ? (ALU_c == OP_MAC ? {{W{1'b0}}, C} : '0) : acc;
    mc_s = idle ? {{W{1'b0}}, A} : mc;
    mp_s = idle ? B : mp;
    acc_n = acc_s + (mp_s[0] ? mc_s : '0);
    rem_s = idle ? '0 : rem;
    quo_s = idle ? A : quo;
    dvs_s = idle ? B : dvs;
    sh = {rem_s, quo_s[W-1]};
    diff = sh - {1'b0, dvs_s};
    rem_n = diff[W] ? sh[W-1:0] : diff[W-1:0];
    quo_n = {quo_s[W-2:0], ~diff[W]};
    fin = state == MUL ? acc_n[W-1:0] : (is_rem ? rem_n : quo_n);
    fin_v = state == MUL && |acc_n[2*W-1:W];
  end
  always_comb begin
    sum = {1'b0, A} + {1'b0, B};
    dif = {1'b0, A} - {1'b0, B};
    big = |B[W-1:SW];
    sa = B[SW-1:0];
    res1 = '0;
    cf1 = 1'b0;
    v1 = 1'b0;
    case (ALU_c)
      OP_PASS: res1 = A;
      OP_ADD: begin
        {cf1, res1} = sum;
        v1 = A[W-1] == B[W-1] && sum[W-1] != A[W-1];
      end
      OP_SUB: begin
        {cf1, res1} = dif;
        v1 = A[W-1] != B[W-1] && dif[W-1] != A[W-1];
      end
      OP_AND: res1 = A & B;
      OP_OR:  res1 = A | B;
      OP_XOR: res1 = A ^ B;
      OP_SHL: res1 = big ? '0 : A << sa;
      OP_SHR: res1 = big ? '0 : A >> sa;
      OP_SRA: res1 = big ? {W{A[W-1]}} : W'($signed(A) >>> sa);
      OP_MUL, OP_MAC: res1 = '0;
      OP_DIV: begin
        res1 = '1;
        v1 = 1'b1;
      end
      OP_REM: begin
        res1 = A;
        v1 = 1'b1;
      end
      OP_SLT: res1 = {{(W-1){1'b0}}, $signed(A) < $signed(B)};
      default: v1 = 1'b1;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= '0;
      z <= 1'b0;
      cf <= 1'b0;
      v <= 1'b0;
      cnt <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      // the accepting edge already performs the first of the WIDTH iterations
      if (fire || !idle) begin
        acc <= acc_n;
        mc <= mc_s << 1;
        mp <= mp_s >> 1;
        rem <= rem_n;
        quo <= quo_n;
        dvs <= dvs_s;
        cnt <= fire ? SW'(1) : cnt + SW'(1);
      end
      if (fire) begin
        is_rem <= ALU_c == OP_REM;
        state <= mul_op ? MUL : div_op ? DIV : IDLE;
        if (!mul_op && !div_op) begin
          result <= res1;
          z <= res1 == '0;
          cf <= cf1;
          v <= v1;
          out_valid <= 1'b1;
        end
      end else if (!idle && cnt == SW'(W-1)) begin
        state <= IDLE;
        result <= fin;
        z <= fin == '0;
        cf <= 1'b0;
        v <= fin_v;
        out_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven scoreboard bench for alu_seq at WIDTH=16
module tb_alu_seq;
  typedef struct packed {
    logic [15:0] res;
    logic z, cf, v;
  } exp_t;
  typedef struct {
    logic [3:0] op;
    logic [15:0] a, b, c;
    exp_t e;
    int lat;
  } vec_t;
  logic clock = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, z, cf, v;
  logic [15:0] A = 0, B = 0, C = 0, result;
  logic [3:0] ALU_c = 0;
  int tests = 0, fails = 0;
  exp_t sb[$];
  exp_t got;
  vec_t vecs[$];
  alu_seq #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .ALU_c(ALU_c), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .z(z), .cf(cf), .v(v)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic void add(input logic [3:0] op, input logic [15:0] a, b, c, res,
                              input logic ez, ecf, ev, input int lat);
    vecs.push_back('{op, a, b, c, '{res, ez, ecf, ev}, lat});
  endfunction
  task automatic issue(input logic [3:0] op, input logic [15:0] a, b, c);
    int n = 0;
    ALU_c = op; A = a; B = b; C = c; in_valid = 1;
    while (!in_ready && n < 100) begin
      @(posedge clock); #1; n++;
    end
    check("accept_in_time", n < 100, 1);
    @(posedge clock); #1;
    in_valid = 0; A = 16'($urandom); B = 16'($urandom); C = 16'($urandom); ALU_c = 4'($urandom);
  endtask
  always @(negedge clock)
    if (!reset && out_valid && out_ready) begin
      got = '{result, z, cf, v};
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got %0h, expected none", got);
      end else check("scoreboard_out", got, sb.pop_front());
    end
  initial begin
    int n;
    bit seen;
    add(1, 16'd6, 16'd14, 0, 16'd20, 0, 0, 0, 1);
    add(1, 16'h7FFF, 16'd1, 0, 16'h8000, 0, 0, 1, 1);
    add(1, 16'hFFFF, 16'd1, 0, 16'h0000, 1, 1, 0, 1);
    add(2, 16'd6, 16'd14, 0, 16'hFFF8, 0, 1, 0, 1);
    add(2, 16'd14, 16'd14, 0, 16'h0000, 1, 0, 0, 1);
    add(2, 16'h8000, 16'd1, 0, 16'h7FFF, 0, 0, 1, 1);
    add(10, 16'd6, 16'd14, 16'd3, 16'd87, 0, 0, 0, 16);
    add(9, 16'h0100, 16'h0100, 0, 16'h0000, 1, 0, 1, 16);
    add(10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 1, 16);
    add(9, 16'h1234, 16'h5678, 0, 16'h0060, 0, 0, 1, 16);
    add(11, 16'd14, 16'd3, 0, 16'd4, 0, 0, 0, 16);
    add(12, 16'd14, 16'd3, 0, 16'd2, 0, 0, 0, 16);
    add(11, 16'hFFFF, 16'd7, 0, 16'h2492, 0, 0, 0, 16);
    add(12, 16'hFFFF, 16'd7, 0, 16'd1, 0, 0, 0, 16);
    add(11, 16'd14, 16'd0, 0, 16'hFFFF, 0, 0, 1, 1);
    add(12, 16'd14, 16'd0, 0, 16'd14, 0, 0, 1, 1);
    add(6, 16'd6, 16'd20, 0, 16'h0000, 1, 0, 0, 1);
    add(6, 16'd6, 16'd3, 0, 16'd48, 0, 0, 0, 1);
    add(8, 16'h8000, 16'd3, 0, 16'hF000, 0, 0, 0, 1);
    add(8, 16'h8000, 16'd16, 0, 16'hFFFF, 0, 0, 0, 1);
    add(7, 16'h8000, 16'd4, 0, 16'h0800, 0, 0, 0, 1);
    add(15, 16'd1, 16'd2, 0, 16'h0000, 1, 0, 1, 1);
    add(14, 16'd1, 16'd2, 0, 16'h0000, 1, 0, 1, 1);
    add(13, 16'hFFFF, 16'd1, 0, 16'd1, 0, 0, 0, 1);
    add(13, 16'd1, 16'hFFFF, 0, 16'd0, 1, 0, 0, 1);
    add(0, 16'h1234, 16'd9, 0, 16'h1234, 0, 0, 0, 1);
    add(3, 16'd6, 16'd14, 0, 16'd6, 0, 0, 0, 1);
    add(4, 16'd6, 16'd9, 0, 16'd15, 0, 0, 0, 1);
    repeat (3) @(posedge clock);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_flags", {result, z, cf, v}, 0);
    check("reset_in_ready", in_ready, 0);
    reset = 0; #1;
    check("post_reset_in_ready", in_ready, 1);
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
      sb.push_back(vecs[i].e);
      n = 1;
      while (!out_valid && n < 100) begin
        check($sformatf("busy_in_ready_%0d", i), in_ready, 0);
        @(posedge clock); #1; n++;
      end
      check($sformatf("latency_%0d", i), n, vecs[i].lat);
      @(posedge clock); #1;
    end
    out_ready = 0;
    issue(5, 16'd6, 16'd14, 0);
    sb.push_back('{16'd8, 1'b0, 1'b0, 1'b0});
    repeat (3) begin
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 16'd8);
      check("bp_in_ready", in_ready, 0);
      @(posedge clock); #1;
    end
    out_ready = 1; #1;
    check("drain_accept_ready", in_ready, 1);
    issue(3, 16'd6, 16'd14, 0);
    sb.push_back('{16'd6, 1'b0, 1'b0, 1'b0});
    check("stream_valid", out_valid, 1);
    check("stream_result", result, 16'd6);
    @(posedge clock); #1;
    check("stream_drained", out_valid, 0);
    issue(9, 16'd3, 16'd5, 0);
    repeat (4) @(posedge clock);
    #1;
    reset = 1;
    @(posedge clock); #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    reset = 0; #1;
    check("abort_recover_ready", in_ready, 1);
    seen = 0;
    repeat (20) begin
      @(posedge clock); #1;
      seen |= out_valid;
    end
    check("abort_no_output", seen, 0);
    issue(1, 16'd1, 16'd2, 0);
    sb.push_back('{16'd3, 1'b0, 1'b0, 1'b0});
    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
